division_restoring_core: RTL and testbench
==========================================

DIVISION_RESTORING_CORE -- requirements
Module: division_restoring_core

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port first_nr  input  WIDTH  dividend, two's complement, from the complement stage.
REQ-005 SHALL have port second_nr  input  WIDTH  divisor, two's complement, from the complement stage.
REQ-006 SHALL have port complement1_finish  input  1  operands-valid level from the complement stage; a rising edge starts a division.
REQ-007 SHALL have port quotient  output  WIDTH  signed quotient, truncated toward zero.
REQ-008 SHALL have port remainder  output  WIDTH  signed remainder, sign of the dividend.
REQ-009 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-010 SHALL have port division_finish  output  1  results valid; level, held high until released.

Function
REQ-011 SHALL register complement1_finish each cycle and detect a start as current=1, previous=0, evaluated in IDLE only.
REQ-012 SHALL implement FSM states IDLE, ITER, SIGN, DONE.
REQ-013 IDLE, start, second_nr!=0: SHALL latch |first_nr| and |second_nr| as WIDTH-bit unsigned, latch both sign bits, clear the partial remainder and iteration counter, and go to ITER.
REQ-014 IDLE, start, second_nr==0: SHALL set quotient=0, remainder=first_nr, div_by_zero=1, division_finish=1, and go to DONE on the same edge.
REQ-015 ITER: SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly WIDTH cycles, then go to SIGN.
REQ-016 SIGN: SHALL negate the quotient magnitude if the sign bits differ, negate the remainder magnitude if the dividend is negative, write quotient/remainder, set division_finish=1, div_by_zero=0, and go to DONE.
REQ-017 Latency: SHALL assert division_finish WIDTH+1 cycles after the start edge (5 for WIDTH=4); divide-by-zero SHALL assert on the start edge.
REQ-018 DONE: SHALL hold all outputs stable while complement1_finish=1; on complement1_finish=0 SHALL clear division_finish and return to IDLE; quotient/remainder/div_by_zero SHALL hold their last values.
REQ-019 SHALL ignore changes on first_nr/second_nr outside the start edge.
REQ-020 Dividend -2^(WIDTH-1): magnitude SHALL be 2^(WIDTH-1) as unsigned; results SHALL wrap modulo 2^WIDTH.
REQ-021 A complement1_finish held high through DONE SHALL NOT start a second division.

Reset
REQ-022 rst=0 SHALL asynchronously force state IDLE, quotient=0, remainder=0, div_by_zero=0, division_finish=0, all internal registers 0, including mid-ITER.
REQ-023 After rst rises, complement1_finish already high SHALL NOT count as a start (previous-value register resets to 1).

Configuration
REQ-024 With macro DIVISION_OVERFLOW_DET_EN defined, SHALL add output div_overflow (1 bit, reset 0), set to 1 in SIGN when dividend=-2^(WIDTH-1) and divisor=-1, cleared at every start; without it, the port and logic SHALL be absent and results wrap per REQ-020.

Structure
REQ-025 SHALL take FSM state encodings (IDLE=2'd0, ITER=2'd1, SIGN=2'd2, DONE=2'd3) and default WIDTH from shared package division_pkg.
REQ-026 SHALL instantiate one combinational sub-module division_restore_step (inputs: partial remainder, next dividend bit, divisor magnitude; outputs: new partial remainder, quotient bit).

Verification
REQ-027 7 / 2, start edge -> after 5 cycles quotient=4'b0011, remainder=4'b0001, division_finish=1, div_by_zero=0.
REQ-028 -7 / 2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1); 6 / -3 -> quotient=4'b1110, remainder=0.
REQ-029 5 / 0 -> on the start edge quotient=0, remainder=4'b0101, div_by_zero=1, division_finish=1.
REQ-030 -8 / -1 -> quotient=4'b1000, remainder=0; div_overflow=1 with DIVISION_OVERFLOW_DET_EN, port absent without it.
REQ-031 rst pulsed low during the 2nd ITER cycle -> all outputs 0 immediately; with complement1_finish still high after release, no division_finish until it drops and rises again.
REQ-032 complement1_finish held high 20 cycles after DONE -> exactly one division; dropping it clears division_finish next edge, quotient held.

Source files
------------

// File: rtl/division_pkg.sv
// Shared definitions for the restoring divider: default width and FSM encodings.
package division_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage : division_pkg

// File: rtl/division_restore_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract the divisor if it fits.
module division_restore_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so the MSB of diff is a clean borrow flag.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial - {1'b0, divisor_i};
        q_o   = ~diff[WIDTH];
        rem_o = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule : division_restore_step

// File: rtl/division_restoring_core.sv
// Signed restoring divider, one quotient bit per cycle, started by a rising edge of complement1_finish.
// Optional overflow flag (-2^(WIDTH-1) / -1) enabled with macro DIVISION_OVERFLOW_DET_EN.
module division_restoring_core
    import division_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] first_nr,
    input  logic [WIDTH-1:0] second_nr,
    input  logic             complement1_finish,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             division_finish
`ifdef DIVISION_OVERFLOW_DET_EN
    ,
    output logic             div_overflow
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic             cf_prev_q;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_n_q, sign_n_d;
    logic             sign_d_q, sign_d_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             fin_q, fin_d;
`ifdef DIVISION_OVERFLOW_DET_EN
    logic             ovf_q, ovf_d;
`endif

    logic             start_c;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign start_c = complement1_finish & ~cf_prev_q;

    division_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (dividend_q[WIDTH-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        sign_n_d    = sign_n_q;
        sign_d_d    = sign_d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        fin_d       = fin_q;
`ifdef DIVISION_OVERFLOW_DET_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
`ifdef DIVISION_OVERFLOW_DET_EN
                    ovf_d = 1'b0;
`endif
                    if (second_nr == '0) begin
                        quotient_d  = '0;
                        remainder_d = first_nr;
                        dbz_d       = 1'b1;
                        fin_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
                        dividend_d = first_nr[WIDTH-1] ? (~first_nr + WIDTH'(1)) : first_nr;
                        divisor_d  = second_nr[WIDTH-1] ? (~second_nr + WIDTH'(1)) : second_nr;
                        sign_n_d   = first_nr[WIDTH-1];
                        sign_d_d   = second_nr[WIDTH-1];
                        rem_d      = '0;
                        quo_d      = '0;
                        cnt_d      = '0;
                        state_d    = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                dividend_d = dividend_q << 1;
                rem_d      = step_rem;
                quo_d      = {quo_q[WIDTH-2:0], step_q};
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                quotient_d  = (sign_n_q ^ sign_d_q) ? (~quo_q + WIDTH'(1)) : quo_q;
                remainder_d = sign_n_q ? (~rem_q + WIDTH'(1)) : rem_q;
                dbz_d       = 1'b0;
                fin_d       = 1'b1;
`ifdef DIVISION_OVERFLOW_DET_EN
                // Magnitude 2^(WIDTH-1) over 1 with both operands negative is exactly min / -1.
                ovf_d = sign_n_q & sign_d_q & (divisor_q == WIDTH'(1))
                      & (quo_q == {1'b1, {(WIDTH-1){1'b0}}});
`endif
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (!complement1_finish) begin
                    fin_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; the edge detector resets high so a held level is not a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cf_prev_q   <= 1'b1;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            sign_n_q    <= 1'b0;
            sign_d_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            fin_q       <= 1'b0;
`ifdef DIVISION_OVERFLOW_DET_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cf_prev_q   <= complement1_finish;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            sign_n_q    <= sign_n_d;
            sign_d_q    <= sign_d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            fin_q       <= fin_d;
`ifdef DIVISION_OVERFLOW_DET_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign quotient        = quotient_q;
    assign remainder       = remainder_q;
    assign div_by_zero     = dbz_q;
    assign division_finish = fin_q;
`ifdef DIVISION_OVERFLOW_DET_EN
    assign div_overflow    = ovf_q;
`endif

endmodule : division_restoring_core

// File: tb/tb_division_restoring_core.sv
// Scoreboard bench for division_restoring_core: directed signed divisions, divide-by-zero, reset and hold cases.
module tb_division_restoring_core;

    logic       clk;
    logic       rst;
    logic [3:0] first_nr;
    logic [3:0] second_nr;
    logic       complement1_finish;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       division_finish;
`ifdef DIVISION_OVERFLOW_DET_EN
    logic       div_overflow;
`endif

    typedef struct {
        logic [3:0]  q;
        logic [3:0]  r;
        logic        dbz;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          errors;
    int          checks;
    logic        fin_prev;

    division_restoring_core #(
        .WIDTH(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .first_nr          (first_nr),
        .second_nr         (second_nr),
        .complement1_finish(complement1_finish),
        .quotient          (quotient),
        .remainder         (remainder),
        .div_by_zero       (div_by_zero),
        .division_finish   (division_finish)
`ifdef DIVISION_OVERFLOW_DET_EN
        ,
        .div_overflow      (div_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising edge of division_finish consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst && division_finish && !fin_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("latency_cycle", cyc, e.cyc);
`ifdef DIVISION_OVERFLOW_DET_EN
                check("div_overflow", 32'(div_overflow), 32'(e.ovf));
`endif
            end
        end
        fin_prev <= division_finish;
    end

    // Start one division at the next edge, wait for it, hold, then release and check the hand-off.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edbz, input logic eovf,
                          input int hold, input bit scramble);
        exp_t e;
        first_nr           = a;
        second_nr          = b;
        complement1_finish = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.ovf = eovf;
        e.cyc = cyc + (edbz ? 1 : 6);
        sb.push_back(e);
        @(negedge clk);
        if (scramble) begin
            first_nr  = ~a;
            second_nr = 4'h0;
        end
        for (int i = 0; i < 20 && division_finish !== 1'b1; i++) @(negedge clk);
        check("finish_timeout", 32'(division_finish), 32'd1);
        repeat (hold) @(negedge clk);
        check("finish_held", 32'(division_finish), 32'd1);
        complement1_finish = 1'b0;
        @(negedge clk);
        check("finish_clear", 32'(division_finish), 32'd0);
        check("quotient_hold", 32'(quotient), 32'(eq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        fin_prev           = 1'b0;
        rst                = 1'b0;
        first_nr           = 4'h0;
        second_nr          = 4'h0;
        complement1_finish = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_finish", 32'(division_finish), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        //     a      b      q      r     dbz   ovf  hold scramble
        do_div(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 2,  1'b1);
        do_div(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'h6, 4'hD, 4'hE, 4'h0, 1'b0, 1'b0, 1,  1'b1);
        do_div(4'h5, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 2,  1'b0);
        do_div(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 1,  1'b0);
        do_div(4'h8, 4'h2, 4'hC, 4'h0, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'h7, 4'h9, 4'hF, 4'h0, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'hF, 4'h3, 4'h0, 4'hF, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'h3, 4'h5, 4'h0, 4'h3, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'h8, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0, 1,  1'b1);
        do_div(4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, 1,  1'b0);
        do_div(4'hB, 4'hE, 4'h2, 4'hF, 1'b0, 1'b0, 20, 1'b0);

        // Reset in the middle of the second iteration cycle, start level still high afterwards.
        first_nr           = 4'h7;
        second_nr          = 4'h2;
        complement1_finish = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        check("midrst_finish", 32'(division_finish), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("no_start_after_rst", 32'(division_finish), 32'd0);
        complement1_finish = 1'b0;
        @(negedge clk);
        do_div(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_division_restoring_core
